// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared constants and priority encoding for the hazard controller
package hazard_ctrl_pkg;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;
  localparam int CNT_W_DEF   = 6;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Which hazard class owns the control outputs this cycle, lowest to highest.
  typedef enum logic [1:0] {
    PRI_NONE   = 2'd0,
    PRI_JUMP   = 2'd1,
    PRI_STALL  = 2'd2,
    PRI_BRANCH = 2'd3
  } hz_pri_e;

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// rtl/hazard_ctrl_md_busy_cnt.sv - MULT/DIV occupancy counter producing md_busy
module md_busy_cnt
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic div,
  output logic md_busy
);

  // The start cycle itself is not counted, so the unit stays busy LAT-1 cycles after the edge.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  logic [CNT_W-1:0] md_cnt;

  // Load on start (a restart while busy reloads), otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt <= '0;
    end else if (start) begin
      md_cnt <= div ? DIV_LOAD : MUL_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_W'(1);
    end
  end

  assign md_busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush controller with MD tracking and stall counter
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_use_rs,
  input  logic        ID_use_rt,
  input  logic        ID_jump,
  input  logic        ID_use_md,
  input  logic        EX_mem_read,
  input  logic [4:0]  EX_rd,
  input  logic        EX_br_taken,
  input  logic        EX_md_start,
  input  logic        EX_md_div,
  output logic        pc_stall,
  output logic        IF_ID_stall,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  logic    lu;
  logic    ms;
  logic    id_stall;
  hz_pri_e pri;

  md_busy_cnt #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_busy_cnt (
    .clk     (clk),
    .rst     (rst),
    .start   (EX_md_start),
    .div     (EX_md_div),
    .md_busy (md_busy)
  );

  // r0 is hardwired zero, and unused source fields are gated off so they never stall.
  assign lu = EX_mem_read && (EX_rd != REG_ZERO) &&
              ((ID_use_rs && (ID_rs == EX_rd)) || (ID_use_rt && (ID_rt == EX_rd)));
  assign ms = md_busy && ID_use_md;
  assign id_stall = lu || ms;

  // Resolve which hazard wins; a taken branch discards the wrong-path ID so its stalls are moot.
  always_comb begin
    pri = PRI_NONE;
    if (EX_br_taken) begin
      pri = PRI_BRANCH;
    end else if (id_stall) begin
      pri = PRI_STALL;
    end else if (ID_jump) begin
      pri = PRI_JUMP;
    end
  end

  // Decode the winning hazard into the pipeline register controls.
  always_comb begin
    pc_stall    = 1'b0;
    IF_ID_stall = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    case (pri)
      PRI_BRANCH: begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end
      PRI_STALL: begin
        pc_stall    = 1'b1;
        IF_ID_stall = 1'b1;
        ID_EX_flush = 1'b1;
      end
      PRI_JUMP: begin
        IF_ID_flush = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Free-running count of PC-hold cycles; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (pc_stall) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard testbench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_use_rs;
  logic        ID_use_rt;
  logic        ID_jump;
  logic        ID_use_md;
  logic        EX_mem_read;
  logic [4:0]  EX_rd;
  logic        EX_br_taken;
  logic        EX_md_start;
  logic        EX_md_div;
  logic        pc_stall;
  logic        IF_ID_stall;
  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic        md_busy;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // ctrl = {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy}
  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       jump;
    logic       use_md;
    logic       mem_read;
    logic [4:0] rd;
    logic       br;
    logic       md_start;
    logic       md_div;
    logic [4:0] ctrl;
  } stim_t;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [31:0] cnt;
  } exp_t;

  localparam logic [4:0] C_IDLE   = 5'b00000;
  localparam logic [4:0] C_LU     = 5'b11010;
  localparam logic [4:0] C_MDST   = 5'b11011;
  localparam logic [4:0] C_BRANCH = 5'b00110;
  localparam logic [4:0] C_JUMP   = 5'b00100;
  localparam logic [4:0] C_BUSY   = 5'b00001;

  exp_t        sb[$];
  logic [31:0] exp_cnt;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ID_rs        (ID_rs),
    .ID_rt        (ID_rt),
    .ID_use_rs    (ID_use_rs),
    .ID_use_rt    (ID_use_rt),
    .ID_jump      (ID_jump),
    .ID_use_md    (ID_use_md),
    .EX_mem_read  (EX_mem_read),
    .EX_rd        (EX_rd),
    .EX_br_taken  (EX_br_taken),
    .EX_md_start  (EX_md_start),
    .EX_md_div    (EX_md_div),
    .pc_stall     (pc_stall),
    .IF_ID_stall  (IF_ID_stall),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_flush  (ID_EX_flush),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                               logic jmp, logic umd, logic mr, logic [4:0] rd, logic br,
                               logic mds, logic mdd, logic [4:0] ctrl);
    stim_t s;
    s.rst = r; s.rs = rs; s.rt = rt; s.use_rs = urs; s.use_rt = urt;
    s.jump = jmp; s.use_md = umd; s.mem_read = mr; s.rd = rd; s.br = br;
    s.md_start = mds; s.md_div = mdd; s.ctrl = ctrl;
    return s;
  endfunction

  task automatic apply(stim_t s);
    rst = s.rst; ID_rs = s.rs; ID_rt = s.rt; ID_use_rs = s.use_rs; ID_use_rt = s.use_rt;
    ID_jump = s.jump; ID_use_md = s.use_md; EX_mem_read = s.mem_read; EX_rd = s.rd;
    EX_br_taken = s.br; EX_md_start = s.md_start; EX_md_div = s.md_div;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    @(posedge clk);
    exp_cnt = 32'd0;
  endtask

  // A new MD op must never arrive while the unit is still occupied.
  always @(posedge clk) begin
    if (!rst && EX_md_start && md_busy) begin
      errors++;
      $display("FAIL md_start_while_busy at %0t", $time);
    end
  end

  // The IF/ID stall/flush pair and the PC hold/flush pair are mutually exclusive.
  always @(negedge clk) begin
    checks++;
    if ((IF_ID_stall && IF_ID_flush) || (pc_stall && IF_ID_flush)) begin
      errors++;
      $display("FAIL exclusive_ctrl got stall=%b pc=%b flush=%b required flush=0",
               IF_ID_stall, pc_stall, IF_ID_flush);
    end
  end

  task automatic test_reset();
    stim_t tab[$];
    exp_t  e;
    tab.push_back(mk(1, 8, 0, 1, 0, 0, 0, 1, 8, 0, 0, 0, C_LU));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    do_reset();
    foreach (tab[i]) begin
      @(posedge clk); #1;
      apply(tab[i]);
      e.ctrl = tab[i].ctrl; e.cnt = exp_cnt;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy} !== e.ctrl || stall_cycles !== e.cnt) begin
        errors++;
        $display("FAIL reset[%0d] got ctrl=%b cnt=%0d required ctrl=%b cnt=%0d", i,
                 {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy}, stall_cycles, e.ctrl, e.cnt);
      end
      if (tab[i].rst) exp_cnt = 32'd0;
      else if (e.ctrl[4]) exp_cnt++;
    end
  endtask

  task automatic test_load_use();
    stim_t tab[$];
    exp_t  e;
    tab.push_back(mk(0, 8, 0, 1, 0, 0, 0, 1, 8, 0, 0, 0, C_LU));     // rs hazard
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));   // released
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, C_IDLE));   // r0 never stalls
    tab.push_back(mk(0, 3, 9, 1, 0, 0, 0, 1, 9, 0, 0, 0, C_IDLE));   // rt match but unused
    tab.push_back(mk(0, 3, 9, 1, 1, 0, 0, 1, 9, 0, 0, 0, C_LU));     // rt hazard
    tab.push_back(mk(0, 9, 9, 1, 1, 0, 0, 0, 9, 0, 0, 0, C_IDLE));   // not a load
    tab.push_back(mk(0, 8, 0, 1, 0, 0, 0, 1, 8, 1, 0, 0, C_BRANCH)); // branch overrides
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    do_reset();
    foreach (tab[i]) begin
      @(posedge clk); #1;
      apply(tab[i]);
      e.ctrl = tab[i].ctrl; e.cnt = exp_cnt;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy} !== e.ctrl || stall_cycles !== e.cnt) begin
        errors++;
        $display("FAIL load_use[%0d] got ctrl=%b cnt=%0d required ctrl=%b cnt=%0d", i,
                 {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy}, stall_cycles, e.ctrl, e.cnt);
      end
      if (e.ctrl[4]) exp_cnt++;
    end
  endtask

  task automatic test_jump();
    stim_t tab[$];
    exp_t  e;
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_JUMP));   // plain jump
    tab.push_back(mk(0, 8, 0, 1, 0, 1, 0, 1, 8, 0, 0, 0, C_LU));     // JR waiting on load
    tab.push_back(mk(0, 8, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, C_JUMP));   // JR now redirects
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, C_BRANCH)); // branch beats jump
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    do_reset();
    foreach (tab[i]) begin
      @(posedge clk); #1;
      apply(tab[i]);
      e.ctrl = tab[i].ctrl; e.cnt = exp_cnt;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy} !== e.ctrl || stall_cycles !== e.cnt) begin
        errors++;
        $display("FAIL jump[%0d] got ctrl=%b cnt=%0d required ctrl=%b cnt=%0d", i,
                 {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy}, stall_cycles, e.ctrl, e.cnt);
      end
      if (e.ctrl[4]) exp_cnt++;
    end
  endtask

  task automatic test_md_occupancy();
    stim_t tab[$];
    exp_t  e;
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, C_IDLE));   // DIV enters
    for (int k = 0; k < 31; k++)
      tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_MDST));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_IDLE));   // result readable
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_IDLE));   // MULT enters
    for (int k = 0; k < 3; k++)
      tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_BUSY));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_IDLE));   // MULT again
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_BRANCH | C_BUSY)); // branch keeps MD
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_BUSY));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_BUSY));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    do_reset();
    foreach (tab[i]) begin
      @(posedge clk); #1;
      apply(tab[i]);
      e.ctrl = tab[i].ctrl; e.cnt = exp_cnt;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy} !== e.ctrl || stall_cycles !== e.cnt) begin
        errors++;
        $display("FAIL md_occupancy[%0d] got ctrl=%b cnt=%0d required ctrl=%b cnt=%0d", i,
                 {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy}, stall_cycles, e.ctrl, e.cnt);
      end
      if (e.ctrl[4]) exp_cnt++;
    end
    checks++;
    if (exp_cnt !== 32'd31) begin
      errors++;
      $display("FAIL div_stall_total got %0d required 31", exp_cnt);
    end
  endtask

  task automatic test_reset_mid_divide();
    stim_t tab[$];
    exp_t  e;
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, C_IDLE));
    for (int k = 0; k < 9; k++)
      tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_MDST));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_MDST));   // 10th busy cycle, reset
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_IDLE));   // divide abandoned
    do_reset();
    foreach (tab[i]) begin
      @(posedge clk); #1;
      apply(tab[i]);
      e.ctrl = tab[i].ctrl; e.cnt = exp_cnt;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy} !== e.ctrl || stall_cycles !== e.cnt) begin
        errors++;
        $display("FAIL reset_mid_div[%0d] got ctrl=%b cnt=%0d required ctrl=%b cnt=%0d", i,
                 {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy}, stall_cycles, e.ctrl, e.cnt);
      end
      if (tab[i].rst) exp_cnt = 32'd0;
      else if (e.ctrl[4]) exp_cnt++;
    end
  endtask

  task automatic test_counter_wrap();
    exp_t e;
    do_reset();
    @(posedge clk); #1;
    apply(mk(0, 8, 0, 1, 0, 0, 0, 1, 8, 0, 0, 0, C_LU));
    force dut.stall_cycles = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cycles;
    exp_cnt = 32'hFFFF_FFFF;
    e.ctrl = C_LU; e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy} !== e.ctrl || stall_cycles !== e.cnt) begin
      errors++;
      $display("FAIL wrap_preload got ctrl=%b cnt=%h required ctrl=%b cnt=%h",
               {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy}, stall_cycles, e.ctrl, e.cnt);
    end
    exp_cnt = exp_cnt + 32'd1;
    @(posedge clk); #1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    e.ctrl = C_IDLE; e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy} !== e.ctrl || stall_cycles !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_result got ctrl=%b cnt=%h required ctrl=%b cnt=00000000",
               {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, md_busy}, stall_cycles, e.ctrl);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    exp_cnt = 32'd0;
    test_reset();
    test_load_use();
    test_jump();
    test_md_occupancy();
    test_reset_mid_divide();
    test_counter_wrap();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives the stall and flush inputs of the IF/ID and ID/EX pipeline registers and the PC hold signal. It covers three hazard classes: load-use data hazards, control redirects (jump resolved in ID, branch resolved in EX), and structural hazards on the multi-cycle MULT/DIV unit, which it tracks with an internal busy counter. It also keeps a free-running stall-cycle performance counter.

Parameters:
MUL_LAT, 4, MULT/MULTU occupancy in cycles (>=2)
DIV_LAT, 32, DIV/DIVU occupancy in cycles (>=2)
CNT_W, 6, busy counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, synchronous, active-high
ID_rs  in  5  rs field of instruction in ID
ID_rt  in  5  rt field of instruction in ID
ID_use_rs  in  1  ID instruction reads rs
ID_use_rt  in  1  ID instruction reads rt
ID_jump  in  1  ID holds J/JAL/JR/JALR (redirect resolved in ID)
ID_use_md  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO/MULT*/DIV*
EX_mem_read  in  1  EX instruction is a load
EX_rd  in  5  destination register of EX instruction
EX_br_taken  in  1  branch in EX resolved taken
EX_md_start  in  1  MULT*/DIV* entering the MD unit this cycle
EX_md_div  in  1  qualifies EX_md_start: 1=divide, 0=multiply
pc_stall  out  1  hold PC
IF_ID_stall  out  1  hold IF/ID register
IF_ID_flush  out  1  load NOP into IF/ID
ID_EX_flush  out  1  load bubble into ID/EX
md_busy  out  1  MD unit occupied
stall_cycles  out  32  count of cycles with pc_stall=1

Behaviour:
- Load-use (lu): EX_mem_read & EX_rd!=0 & ((ID_use_rs & ID_rs==EX_rd) | (ID_use_rt & ID_rt==EX_rd)).
- MD structural (ms): md_busy & ID_use_md.
- id_stall = lu | ms.
- All control outputs are combinational from the current inputs and registered state, valid in the same cycle.
- Priority, highest first:
  1. EX_br_taken: IF_ID_flush=1, ID_EX_flush=1, pc_stall=0, IF_ID_stall=0. Wrong-path ID is discarded, so lu/ms are ignored and the PC loads the branch target.
  2. id_stall: pc_stall=1, IF_ID_stall=1, ID_EX_flush=1, IF_ID_flush=0.
  3. ID_jump: IF_ID_flush=1 only. The slot fetched after the jump is squashed; no delay slot. A jump that is itself stalled (e.g. JR load-use) is handled by case 2 first and flushes on the first unstalled cycle.
  4. Otherwise: all four control outputs are 0.
- The IF_ID stall/flush pair must never be 1/1 simultaneously, and neither may the pc_stall/flush pair.
- MD counter md_cnt[CNT_W-1:0]; md_busy = (md_cnt != 0):
  - EX_md_start=1 loads DIV_LAT-1 if EX_md_div, else MUL_LAT-1. Start takes precedence over decrement, so a start while busy reloads. The pipeline never produces this; the bench asserts it does not occur.
  - Else, if md_cnt != 0, decrement by 1.
  - Total busy cycles after the start edge = LAT-1, so the result is readable LAT cycles after the start cycle.
  - EX_br_taken does not clear md_cnt: an MD op already in EX is older than the branch and commits.
- stall_cycles increments by 1 on every clock edge where pc_stall=1 and wraps modulo 2^32. No saturation.
- Reset (rst=1 at a clock edge): md_cnt=0, stall_cycles=0.
  - Outputs after reset: md_busy=0. Control outputs follow the input equations; with idle inputs they are all 0.
  - Reset mid-divide abandons the operation immediately; the next cycle has md_busy=0.
- Register 0 never causes a load-use stall. ID_use_* gate the comparison, so unused fields never stall.

Decomposition:
- Shared package/header: MUL_LAT/DIV_LAT defaults, the REG_ZERO constant (5'd0), and the priority encoding as localparams for assertions.
- One sub-module: md_busy_cnt (load/decrement counter producing md_busy). The remaining logic is the combinational hazard/priority network plus stall_cycles in the top.

Test Plan:
- Load-use: EX_mem_read=1, EX_rd=8; ID_rs=8, ID_use_rs=1 → pc_stall=IF_ID_stall=ID_EX_flush=1 for exactly that cycle; stall_cycles increments 0→1. Repeat with EX_rd=0 → no stall.
- Taken branch during load-use: as above plus EX_br_taken=1 → IF_ID_flush=ID_EX_flush=1, pc_stall=0, stall_cycles unchanged.
- Jump: ID_jump=1, no hazards → IF_ID_flush=1, all other controls 0. JR with rs load-use → stall first cycle, IF_ID_flush=1 the next cycle.
- Divide occupancy: EX_md_start=1, EX_md_div=1 with default DIV_LAT=32 → md_busy=1 for 31 cycles after the edge. ID_use_md=1 held throughout → 31 stalled cycles, stall_cycles=31, released when md_cnt reaches 0. Multiply with default MUL_LAT=4 → 3 busy cycles.
- Reset mid-divide: assert rst at the 10th busy cycle → next cycle md_busy=0 and stall_cycles=0.
- Counter wrap: preload or force stall_cycles=32'hFFFF_FFFF, one stall cycle → 32'h0000_0000.
